// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch unit.
//   - ifu_state_t : fetch FSM state encoding
//   - IFU_PC_RESET: default PC after reset
//   - IFU_XLEN    : datapath width seen by idu (if_inst width)
//   - IFU_INST_W  : raw instruction width returned by imem
//   - IFU_PC_STEP : PC increment per fetched instruction
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ifu_state_t;

  localparam logic [63:0] IFU_PC_RESET = 64'h0000_0000_8000_0000;
  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_INST_W   = 32;
  localparam int          IFU_PC_STEP  = 4;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: small synchronous FIFO holding fetched {instruction, pc} pairs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear of all entries (wins over push/pop)
//   push/push_data : write one entry (ignored when full unless popping)
//   pop        : consume head entry (ignored when empty)
//   pop_data   : head entry (undefined content when empty; caller gates it)
//   empty      : no entries stored
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is not reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Owns the PC, issues single-beat requests
// to instruction memory (one outstanding at most), buffers returned
// instructions and hands them to idu over a valid/ready link.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req_valid/ready/addr   : fetch request channel (addr 4-byte aligned)
//   imem_rsp_valid/data         : response beat, no backpressure
//   redirect_valid/redirect_pc  : load a new PC and flush the fetch path
//   if_valid/if_ready           : handshake to idu
//   if_inst                     : zero-extended instruction at the buffer head
//   if_pc                       : PC of if_inst
//   if_misalign                 : only when IFU_MISALIGN_CHK_EN is defined
// Configuration macro IFU_MISALIGN_CHK_EN: a misaligned redirect target
// stalls fetch and raises if_misalign until the next aligned redirect.
// Without it, redirect_pc[1:0] is treated as 2'b00.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(IFU_PC_RESET),
  parameter int                INST_W    = IFU_INST_W,
  parameter int                BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_W-1:0]   imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [IFU_XLEN-1:0] if_inst,
  output logic [ADDR_W-1:0]   if_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic                if_misalign
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int ENT_W = INST_W + ADDR_W;

  ifu_state_t        state;
  ifu_state_t        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_pc_nxt;
  logic              drop;
  logic              drop_nxt;

  logic [ADDR_W-1:0] redir_target;
  logic              misalign_stall;

  logic              rsp_fire;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    count_nxt;
  logic              credit_ok;
  logic              start_req;
  logic [ENT_W-1:0]  head;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q;

  // Every redirect re-evaluates alignment, so an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end

  assign misalign_stall = misalign_q;
  assign if_misalign    = misalign_q;
  assign redir_target   = redirect_pc;
`else
  assign misalign_stall = 1'b0;
  assign redir_target   = redirect_pc & ~ADDR_W'(3);
`endif

  // Only a response to our own outstanding request is meaningful.
  assign rsp_fire = (state == S_WAIT) && imem_rsp_valid;
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push     = rsp_fire && !drop && !redirect_valid;
  assign pop      = if_valid && if_ready;

  // Credit check uses the occupancy the buffer will have after this cycle,
  // which lets a new request start in the response cycle (2-cycle cadence).
  assign count_nxt = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign credit_ok = (count_nxt < (CNT_W+1)'(BUF_DEPTH));
  assign start_req = !redirect_valid && !misalign_stall && credit_ok;

  // State register and fetch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_VAL;
      req_pc <= RESET_VAL;
      drop   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
      drop   <= drop_nxt;
    end
  end

  // Next-state logic. req_pc freezes the request address while in S_REQ so a
  // redirect cannot disturb an unaccepted request; the stale request is
  // completed and its response dropped. The PC only advances on accept of a
  // request that still belongs to the current stream.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    drop_nxt   = drop;

    case (state)
      S_IDLE: begin
        if (start_req) begin
          state_nxt  = S_REQ;
          req_pc_nxt = pc;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          if (!drop && !redirect_valid) begin
            pc_nxt = req_pc + ADDR_W'(IFU_PC_STEP);
          end
        end
        if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (start_req) begin
            state_nxt  = S_REQ;
            req_pc_nxt = pc;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_nxt = redir_target;
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = req_pc;

  ifu_fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, req_pc}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_inst = head[ENT_W-1:ADDR_W];
  assign head_pc   = head[ADDR_W-1:0];

  // Outputs read as zero when nothing is buffered.
  assign if_valid = !fifo_empty;
  assign if_inst  = if_valid ? {{(IFU_XLEN-INST_W){1'b0}}, head_inst} : '0;
  assign if_pc    = if_valid ? head_pc : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch. Expected fetch addresses and
// delivered instructions are queued as stimulus is issued; a monitor pops and
// compares on every accepted request and every idu transfer. The memory model
// returns addr[31:0]^32'h13 as the instruction, after a programmable delay.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_inst;
  logic [63:0] if_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } if_exp_t;

  if_exp_t     exp_if_q[$];
  logic [63:0] exp_req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rsp_delay = 0;
  logic        pending;
  logic [63:0] pend_addr;
  int          wait_cnt;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  // Memory model: one request at a time, response after rsp_delay extra cycles.
  always @(posedge clk) begin
    if (rst) begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
      pending        <= 1'b0;
      pend_addr      <= 64'h0;
      wait_cnt       <= 0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (pending) begin
        if (wait_cnt == 0) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= pend_addr[31:0] ^ 32'h13;
          pending        <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 1;
        end
      end else if (imem_req_valid && imem_req_ready) begin
        if (rsp_delay == 0) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= imem_req_addr[31:0] ^ 32'h13;
        end else begin
          pending   <= 1'b1;
          pend_addr <= imem_req_addr;
          wait_cnt  <= rsp_delay - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expectReq(input logic [63:0] addr);
    exp_req_q.push_back(addr);
  endtask

  task automatic expectIf(input logic [63:0] pc, input logic [31:0] inst);
    if_exp_t e;
    e.pc   = pc;
    e.inst = inst;
    exp_if_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic mem_rdy, input logic id_rdy, input int ncycles);
    imem_req_ready = mem_rdy;
    if_ready       = id_rdy;
    repeat (ncycles) @(negedge clk);
  endtask

  task automatic redirectPulse(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Empty the buffer with memory stalled; the DUT then sits in S_REQ.
  task automatic drain();
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!if_valid) break;
    end
    if_ready = 1'b0;
    checkOutput("drain_empty", 64'(if_valid), 64'h0);
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled inputs.
  always @(negedge clk) begin : monitor
    if_exp_t     e;
    logic [63:0] a;
    #3;
    if (!rst) begin
      if (if_valid && if_ready) begin
        if (exp_if_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL if_unexpected: got pc %h expected no transfer", if_pc);
        end else begin
          e = exp_if_q.pop_front();
          checkOutput("if_pc", if_pc, e.pc);
          checkOutput("if_inst", if_inst, {32'h0, e.inst});
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
        end else begin
          a = exp_req_q.pop_front();
          checkOutput("req_addr", imem_req_addr, a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'h0);
    checkOutput("rst_if_valid", 64'(if_valid), 64'h0);
    checkOutput("rst_if_inst", if_inst, 64'h0);
    checkOutput("rst_if_pc", if_pc, 64'h0);
    rst = 1'b0;

    $display("[TB] sequential fetch and buffer full");
    expectReq(64'h8000_0000);
    expectReq(64'h8000_0004);
    expectIf(64'h8000_0000, 32'h8000_0013);
    expectIf(64'h8000_0004, 32'h8000_0017);
    applyStimulus(1'b1, 1'b0, 12);
    checkOutput("full_req_valid", 64'(imem_req_valid), 64'h0);
    checkOutput("full_if_valid", 64'(if_valid), 64'h1);
    checkOutput("full_head_pc", if_pc, 64'h8000_0000);
    checkOutput("full_head_inst", if_inst, 64'h8000_0013);
    drain();
    checkOutput("next_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("next_req_addr", imem_req_addr, 64'h8000_0008);

    $display("[TB] held request plus redirect");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_addr", imem_req_addr, 64'h8000_0008);
    end
    redirectPulse(64'h8000_0100);
    checkOutput("hold_after_redir_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("hold_after_redir_addr", imem_req_addr, 64'h8000_0008);
    expectReq(64'h8000_0008);
    expectReq(64'h8000_0100);
    expectReq(64'h8000_0104);
    expectIf(64'h8000_0100, 32'h8000_0113);
    expectIf(64'h8000_0104, 32'h8000_0117);
    applyStimulus(1'b1, 1'b0, 15);
    drain();

    $display("[TB] redirect while waiting for response");
    rsp_delay = 3;
    expectReq(64'h8000_0108);
    expectReq(64'h8000_0200);
    expectReq(64'h8000_0204);
    expectIf(64'h8000_0200, 32'h8000_0213);
    expectIf(64'h8000_0204, 32'h8000_0217);
    applyStimulus(1'b1, 1'b0, 1);
    redirectPulse(64'h8000_0200);
    applyStimulus(1'b1, 1'b0, 30);
    drain();
    rsp_delay = 0;

    $display("[TB] back-to-back redirects and pc wrap");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    @(negedge clk);
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    expectReq(64'h8000_0208);
    expectReq(64'hFFFF_FFFF_FFFF_FFF8);
    expectReq(64'hFFFF_FFFF_FFFF_FFFC);
    expectIf(64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFEB);
    expectIf(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFEF);
    applyStimulus(1'b1, 1'b0, 15);
    drain();
    checkOutput("wrap_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("wrap_req_addr", imem_req_addr, 64'h0);

    $display("[TB] redirect in idle with pop in the same cycle");
    expectReq(64'h0);
    expectReq(64'h4);
    applyStimulus(1'b1, 1'b0, 12);
    expectIf(64'h0, 32'h0000_0013);
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    checkOutput("flush_if_valid", 64'(if_valid), 64'h0);
    checkOutput("idle_redir_no_req", 64'(imem_req_valid), 64'h0);
    @(negedge clk);
    checkOutput("idle_redir_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("idle_redir_req_addr", imem_req_addr, 64'h8000_0400);
    expectReq(64'h8000_0400);
    expectReq(64'h8000_0404);
    expectIf(64'h8000_0400, 32'h8000_0413);
    expectIf(64'h8000_0404, 32'h8000_0417);
    applyStimulus(1'b1, 1'b0, 12);
    drain();

    expectReq(64'h8000_0408);
`ifdef IFU_MISALIGN_CHK_EN
    $display("[TB] misaligned redirect stalls fetch");
    redirectPulse(64'h8000_0002);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("misalign_set", 64'(if_misalign), 64'h1);
    checkOutput("misalign_no_req", 64'(imem_req_valid), 64'h0);
    redirectPulse(64'h8000_0500);
    checkOutput("misalign_clear", 64'(if_misalign), 64'h0);
    expectReq(64'h8000_0500);
    expectReq(64'h8000_0504);
    applyStimulus(1'b1, 1'b0, 12);
`else
    $display("[TB] low redirect bits ignored");
    redirectPulse(64'h8000_0503);
    expectReq(64'h8000_0500);
    expectReq(64'h8000_0504);
    applyStimulus(1'b1, 1'b0, 20);
`endif
    checkOutput("final_head_pc", if_pc, 64'h8000_0500);
    checkOutput("final_head_inst", if_inst, 64'h8000_0513);
    checkOutput("final_req_valid", 64'(imem_req_valid), 64'h0);

    @(negedge clk);
    checkOutput("if_queue_left", 64'(exp_if_q.size()), 64'h0);
    checkOutput("req_queue_left", 64'(exp_req_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
